mdio_master: RTL and testbench

- Parametrised IEEE 802.3 Clause 22 MDIO management master; successor to the fixed-sequence PHY configuration shifter.
- Runs arbitrary read/write transactions to any PHY address and register from a valid/ready command port.
- Generates a divided MDC, frames preamble/ST/OP/addresses/TA/data, and returns read data plus an ack-error flag.
- Sits between the Ethernet bring-up sequencer and the PHY pins; the top level owns the MDIO tristate pad.

---
 rtl/mdio_master.sv | 203 ++++++++++++++++++++
 tb/tb_mdio_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO management master with a valid/ready
// command port, divided MDC, and read data / ack-error response.
// Optional feature macro: MDIO_PRE_SUPPRESS_EN adds cmd_nopre, which skips the
// preamble for the accepted command.
module mdio_master #(
  parameter int unsigned CLK_DIV = 20,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
  input  logic        cmd_nopre,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int unsigned PERIOD   = 2 * CLK_DIV;
  localparam int unsigned DIV_W    = $clog2(PERIOD);
  localparam int unsigned BIT_W    = 7;
  localparam int unsigned TA_OFS   = 14;
  localparam int unsigned DATA_OFS = 16;
  localparam int unsigned LAST_OFS = 31;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_TA_RD = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state,   w_state;
  logic [DIV_W-1:0] r_div,     w_div;
  logic [BIT_W-1:0] r_bit,     w_bit;
  logic             r_write,   w_write;
  logic [4:0]       r_phy,     w_phy;
  logic [4:0]       r_reg,     w_reg;
  logic [15:0]      r_wdata,   w_wdata;
  logic             r_nopre,   w_nopre;
  logic [15:0]      r_rd_shift, w_rd_shift;
  logic             r_ta_err,  w_ta_err;
  logic             r_mdc,     w_mdc;
  logic             r_mdio_o,  w_mdio_o;
  logic             r_mdio_oe, w_mdio_oe;
  logic             r_busy,    w_busy;
  logic             r_ready,   w_ready;
  logic             r_rsp_valid, w_rsp_valid;
  logic [15:0]      r_rdata,   w_rdata;
  logic             r_err,     w_err;

  logic [BIT_W-1:0] w_pre_cur;
  logic [BIT_W-1:0] w_pre_nxt;
  logic [BIT_W-1:0] w_idx;
  logic [31:0]      w_frame;
  logic             w_active;

  // Preamble length of the command currently in flight
  assign w_pre_cur = r_nopre ? '0 : BIT_W'(PRE_LEN);

  // Next-state, bit sequencing, sampling and next output values
  always_comb begin
    w_state     = r_state;
    w_div       = r_div;
    w_bit       = r_bit;
    w_write     = r_write;
    w_phy       = r_phy;
    w_reg       = r_reg;
    w_wdata     = r_wdata;
    w_nopre     = r_nopre;
    w_rd_shift  = r_rd_shift;
    w_ta_err    = r_ta_err;
    w_rsp_valid = 1'b0;
    w_rdata     = r_rdata;
    w_err       = r_err;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_write  = cmd_write;
          w_phy    = cmd_phy;
          w_reg    = cmd_reg;
          w_wdata  = cmd_wdata;
`ifdef MDIO_PRE_SUPPRESS_EN
          w_nopre  = cmd_nopre;
`endif
          w_state  = S_SHIFT;
          w_div    = '0;
          w_bit    = '0;
          w_ta_err = 1'b0;
        end
      end
      S_SHIFT, S_TA_RD, S_READ: begin
        // Sample the line in the first cycle of MDC high
        if (r_div == DIV_W'(CLK_DIV)) begin
          if ((r_state == S_TA_RD) && (r_bit == w_pre_cur + BIT_W'(TA_OFS + 1)))
            w_ta_err = mdio_i;
          if (r_state == S_READ)
            w_rd_shift = {r_rd_shift[14:0], mdio_i};
        end
        if (r_div == DIV_W'(PERIOD - 1)) begin
          w_div = '0;
          if (r_bit == w_pre_cur + BIT_W'(LAST_OFS)) begin
            w_state     = S_DONE;
            w_rsp_valid = 1'b1;
            if (r_write) begin
              w_err = 1'b0;
            end else begin
              w_err   = w_ta_err;
              w_rdata = w_rd_shift;
            end
          end else begin
            w_bit = r_bit + BIT_W'(1);
            if (!r_write && (w_bit == w_pre_cur + BIT_W'(TA_OFS)))
              w_state = S_TA_RD;
            else if ((r_state == S_TA_RD) && (w_bit == w_pre_cur + BIT_W'(DATA_OFS)))
              w_state = S_READ;
          end
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Pin values for the next cycle; the line is released outside a frame
    w_pre_nxt = w_nopre ? '0 : BIT_W'(PRE_LEN);
    w_active  = (w_state == S_SHIFT) || (w_state == S_TA_RD) || (w_state == S_READ);
    w_frame   = {2'b01, (w_write ? 2'b01 : 2'b10), w_phy, w_reg, 2'b10, w_wdata};
    w_idx     = w_bit - w_pre_nxt;
    w_mdc     = w_active && (w_div >= DIV_W'(CLK_DIV));
    w_mdio_oe = w_active && (w_write || (w_bit < w_pre_nxt + BIT_W'(TA_OFS)));
    w_mdio_o  = 1'b1;
    if (w_mdio_oe && (w_bit >= w_pre_nxt))
      w_mdio_o = w_frame[5'(BIT_W'(LAST_OFS) - w_idx)];
    w_busy    = (w_state != S_IDLE);
    w_ready   = (w_state == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_write     <= 1'b0;
      r_phy       <= '0;
      r_reg       <= '0;
      r_wdata     <= '0;
      r_nopre     <= 1'b0;
      r_rd_shift  <= '0;
      r_ta_err    <= 1'b0;
      r_mdc       <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_div       <= w_div;
      r_bit       <= w_bit;
      r_write     <= w_write;
      r_phy       <= w_phy;
      r_reg       <= w_reg;
      r_wdata     <= w_wdata;
      r_nopre     <= w_nopre;
      r_rd_shift  <= w_rd_shift;
      r_ta_err    <= w_ta_err;
      r_mdc       <= w_mdc;
      r_mdio_o    <= w_mdio_o;
      r_mdio_oe   <= w_mdio_oe;
      r_busy      <= w_busy;
      r_ready     <= w_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rdata     <= w_rdata;
      r_err       <= w_err;
    end
  end

  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign busy      = r_busy;
  assign mdc       = r_mdc;
  assign mdio_o    = r_mdio_o;
  assign mdio_oe   = r_mdio_oe;

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: vector table + scoreboard bench for mdio_master with a
// bit-level PHY model on the MDIO pad.
`timescale 1ns/1ps
module tb_mdio_master;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned PRE_LEN = 32;
  localparam int unsigned PERIOD  = 2 * CLK_DIV;

  localparam logic [1:0] M_PULLUP = 2'd0;  // no PHY, line pulled high
  localparam logic [1:0] M_ACK    = 2'd1;  // Z, 0, then data
  localparam logic [1:0] M_BADTA  = 2'd2;  // Z, 1, then data

  typedef struct {
    int          id;
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [1:0]  mode;
    logic [15:0] resp;
    logic        nopre;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy = '0;
  logic [4:0]  cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
`ifdef MDIO_PRE_SUPPRESS_EN
  logic        cmd_nopre = 1'b0;
`endif
  logic        cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe, mdio_i;
  logic [15:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t        tv[8];
  vec_t        pend;
  vec_t        cur;
  vec_t        sb_q[$];
  int unsigned cyc = 0;
  logic        in_frame = 1'b0;
  int          acc_cnt = 0, rsp_cnt = 0, rsp_seen = 0;
  int          gcyc = 0, acc_gcyc = 0, rsp_gcyc = 0;
  logic [95:0] cap_o, cap_oe;
  logic        mdc_bad, hold_bad, stab_bad;
  logic        phy_line;
  int unsigned pb, pr, mb, mph, mflen;

  mdio_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
    .cmd_nopre(cmd_nopre),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned pre_of(input vec_t v);
    return v.nopre ? 0 : PRE_LEN;
  endfunction

  // Reference frame: bit b of the returned vectors is bit period b
  function automatic void model_stream(input vec_t e, output logic [95:0] eo, output logic [95:0] eoe);
    int unsigned pre;
    logic [31:0] fr;
    pre = pre_of(e);
    fr  = {2'b01, (e.write ? 2'b01 : 2'b10), e.phy, e.regad, 2'b10, e.wdata};
    eo  = '0;
    eoe = '0;
    for (int b = 0; b < int'(pre); b++) begin
      eo[b]  = 1'b1;
      eoe[b] = 1'b1;
    end
    for (int k = 0; k < 32; k++) begin
      eo[int'(pre) + k]  = fr[31 - k];
      eoe[int'(pre) + k] = e.write || (k < 14);
    end
  endfunction

  always @(posedge clk) gcyc <= gcyc + 1;

  // Acceptance detection: push expectation, restart frame cycle counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame <= 1'b0;
      cyc      <= 0;
    end else if (cmd_valid && cmd_ready) begin
      sb_q.push_back(pend);
      cur      <= pend;
      cyc      <= 0;
      in_frame <= 1'b1;
      acc_cnt  <= acc_cnt + 1;
      acc_gcyc <= gcyc;
    end else if (in_frame && cyc < 4000) begin
      cyc <= cyc + 1;
    end
  end

  // PHY model: changes only at bit-period boundaries
  always_comb begin
    phy_line = 1'b1;
    pb = cyc / PERIOD;
    pr = pre_of(cur);
    if (in_frame && cur.mode != M_PULLUP) begin
      if (pb == pr + 15)
        phy_line = (cur.mode == M_BADTA);
      else if (pb >= pr + 16 && pb <= pr + 31)
        phy_line = cur.resp[15 - int'(pb - pr - 16)];
    end
  end
  assign mdio_i = mdio_oe ? mdio_o : phy_line;

  // Pin monitor and response scoreboard
  always @(negedge clk) begin
    vec_t        e;
    logic [95:0] eo, eoe;
    if (rst_n && in_frame) begin
      mflen = pre_of(cur) + 32;
      if (cyc < mflen * PERIOD) begin
        mb  = cyc / PERIOD;
        mph = cyc % PERIOD;
        if (cyc == 0) begin
          cap_o = '0; cap_oe = '0;
          mdc_bad = 1'b0; hold_bad = 1'b0; stab_bad = 1'b0;
        end
        if (mph == 0) begin
          cap_o[mb]  = mdio_o;
          cap_oe[mb] = mdio_oe;
        end else if (mdio_o !== cap_o[mb] || mdio_oe !== cap_oe[mb]) begin
          stab_bad = 1'b1;
        end
        if (mdc !== (mph >= CLK_DIV)) mdc_bad = 1'b1;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) hold_bad = 1'b1;
      end
    end
    if (rst_n && rsp_valid) begin
      rsp_seen++;
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 96'(rsp_valid), 96'(0));
      end else begin
        e = sb_q.pop_front();
        model_stream(e, eo, eoe);
        chk($sformatf("latency[%0d]", e.id), 96'(cyc + 1), 96'((pre_of(e) + 32) * PERIOD + 1));
        chk($sformatf("rdata[%0d]", e.id), 96'(rsp_rdata), 96'(e.exp_rdata));
        chk($sformatf("err[%0d]", e.id), 96'(rsp_err), 96'(e.exp_err));
        chk($sformatf("oe_stream[%0d]", e.id), cap_oe, eoe);
        chk($sformatf("o_stream[%0d]", e.id), cap_o & eoe, eo & eoe);
        chk($sformatf("mdc_shape[%0d]", e.id), 96'(mdc_bad), 96'(0));
        chk($sformatf("busy_ready[%0d]", e.id), 96'(hold_bad), 96'(0));
        chk($sformatf("bit_stable[%0d]", e.id), 96'(stab_bad), 96'(0));
        chk($sformatf("done_pins[%0d]", e.id), 96'({mdc, mdio_oe, mdio_o, busy, cmd_ready}), 96'(5'b00110));
        rsp_gcyc = gcyc;
        rsp_cnt++;
      end
    end
  end

  task automatic drive(input vec_t v);
    pend      = v;
    cmd_write = v.write;
    cmd_phy   = v.phy;
    cmd_reg   = v.regad;
    cmd_wdata = v.wdata;
`ifdef MDIO_PRE_SUPPRESS_EN
    cmd_nopre = v.nopre;
`endif
  endtask

  task automatic wait_acc(input int a0, input int limit);
    int n = 0;
    while (acc_cnt == a0 && n < limit) begin @(negedge clk); n++; end
    if (acc_cnt == a0) chk("accept_timeout", 96'(0), 96'(1));
  endtask

  task automatic wait_rsp(input int r0);
    int n = 0;
    while (rsp_cnt == r0 && n < 1000) begin @(negedge clk); n++; end
    if (rsp_cnt == r0) chk("rsp_timeout", 96'(0), 96'(1));
  endtask

  task automatic run_cmd(input vec_t v);
    int a0, r0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    drive(v);
    cmd_valid = 1'b1;
    wait_acc(a0, 20);
    cmd_valid = 1'b0;
    wait_rsp(r0);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input int id, input logic wr, input logic [4:0] phy,
                              input logic [4:0] rg, input logic [15:0] wd, input logic [1:0] md,
                              input logic [15:0] rs, input logic np,
                              input logic [15:0] erd, input logic eerr);
    vec_t v;
    v.id = id; v.write = wr; v.phy = phy; v.regad = rg; v.wdata = wd;
    v.mode = md; v.resp = rs; v.nopre = np; v.exp_rdata = erd; v.exp_err = eerr;
    return v;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb;
    logic [31:0] hdr, hdr_exp;
    int a0, r0, s0, n;

    tv[0] = mk(0, 1'b1, 5'd1,  5'd0,  16'h1200, M_PULLUP, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tv[1] = mk(1, 1'b0, 5'd3,  5'd2,  16'h0000, M_ACK,    16'h0141, 1'b0, 16'h0141, 1'b0);
    tv[2] = mk(2, 1'b0, 5'd7,  5'd1,  16'h0000, M_PULLUP, 16'h0000, 1'b0, 16'hFFFF, 1'b1);
    tv[3] = mk(3, 1'b1, 5'd31, 5'd31, 16'hA5C3, M_PULLUP, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
    tv[4] = mk(4, 1'b0, 5'd0,  5'd1,  16'h0000, M_ACK,    16'h8001, 1'b0, 16'h8001, 1'b0);
    tv[5] = mk(5, 1'b0, 5'd10, 5'd17, 16'h0000, M_BADTA,  16'h1234, 1'b0, 16'h1234, 1'b1);
    tv[6] = mk(6, 1'b1, 5'd21, 5'd10, 16'hFFFF, M_PULLUP, 16'h0000, 1'b0, 16'h1234, 1'b0);
    tv[7] = mk(7, 1'b1, 5'd2,  5'd4,  16'h0000, M_PULLUP, 16'h0000, 1'b0, 16'h1234, 1'b0);
    pend = tv[0];

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_pins", 96'({mdc, mdio_o, mdio_oe, busy, rsp_valid, cmd_ready, rsp_err}), 96'(7'b0100010));
    chk("reset_rdata", 96'(rsp_rdata), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_pins", 96'({mdc, mdio_o, mdio_oe, busy, cmd_ready}), 96'(5'b01001));

    for (int i = 0; i < 8; i++) begin
      run_cmd(tv[i]);
      if (i == 0) begin
        for (int k = 0; k < 32; k++) hdr[31 - k] = cap_o[32 + k];
        hdr_exp = 32'b0101_00001_00000_10_0001001000000000;
        chk("write_header_literal", 96'(hdr), 96'(hdr_exp));
        chk("write_preamble_literal", 96'(cap_o[31:0]), 96'(32'hFFFF_FFFF));
      end
    end

    // Back-to-back: cmd_valid held across two commands
    va = mk(8, 1'b0, 5'd1, 5'd3, 16'h0000, M_ACK,    16'hBEEF, 1'b0, 16'hBEEF, 1'b0);
    vb = mk(9, 1'b1, 5'd1, 5'd4, 16'h0001, M_PULLUP, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
    a0 = acc_cnt;
    r0 = rsp_cnt;
    drive(va);
    cmd_valid = 1'b1;
    wait_acc(a0, 20);
    drive(vb);
    wait_acc(a0 + 1, 1000);
    cmd_valid = 1'b0;
    chk("b2b_first_rsp", 96'(rsp_cnt - r0), 96'(1));
    chk("b2b_gap", 96'(acc_gcyc - rsp_gcyc), 96'(1));
    wait_rsp(r0 + 1);
    @(negedge clk);

    // Reset during bit 40 of a write aborts with no response
    va = mk(10, 1'b1, 5'd5, 5'd9, 16'h3C3C, M_PULLUP, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
    a0 = acc_cnt;
    drive(va);
    cmd_valid = 1'b1;
    wait_acc(a0, 20);
    cmd_valid = 1'b0;
    n = 0;
    while (cyc < 40 * PERIOD && n < 400) begin @(negedge clk); n++; end
    s0 = rsp_seen;
    rst_n = 1'b0;
    #1;
    chk("abort_pins", 96'({mdc, mdio_o, mdio_oe, busy, rsp_valid, cmd_ready, rsp_err}), 96'(7'b0100010));
    chk("abort_rdata", 96'(rsp_rdata), 96'(0));
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_no_rsp", 96'(rsp_seen - s0), 96'(0));
    chk("abort_idle", 96'({busy, cmd_ready, mdio_oe, mdc}), 96'(4'b0100));
    run_cmd(mk(11, 1'b0, 5'd5, 5'd9, 16'h0000, M_ACK, 16'h5A5A, 1'b0, 16'h5A5A, 1'b0));

`ifdef MDIO_PRE_SUPPRESS_EN
    // Preamble suppression: ST is the first bit, 32-bit frame
    run_cmd(mk(12, 1'b1, 5'd4, 5'd0, 16'h8000, M_PULLUP, 16'h0000, 1'b1, 16'h5A5A, 1'b0));
    chk("nopre_first_bit", 96'(cap_o[0]), 96'(0));
    run_cmd(mk(13, 1'b1, 5'd4, 5'd0, 16'h8000, M_PULLUP, 16'h0000, 1'b0, 16'h5A5A, 1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
